// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: two OBI hosts (0 = instruction fetch, 1 = data) share one
// OBI device port. The winning address phase is forwarded unchanged, the
// winner's index is queued in an in-order ID FIFO, and each response is
// routed back to the host at the FIFO head.
// Optional feature macro: LUCID64_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, host 1 has fixed priority over host 0.
module obi_mem_arbiter #(
  parameter int unsigned OUTSTANDING_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // host 0 (instruction fetch)
  input  logic        h0_req_i,
  output logic        h0_gnt_o,
  input  logic [63:0] h0_addr_i,
  input  logic        h0_we_i,
  input  logic [7:0]  h0_be_i,
  input  logic [63:0] h0_wdata_i,
  output logic        h0_rvalid_o,
  output logic [63:0] h0_rdata_o,
  // host 1 (data memory stage)
  input  logic        h1_req_i,
  output logic        h1_gnt_o,
  input  logic [63:0] h1_addr_i,
  input  logic        h1_we_i,
  input  logic [7:0]  h1_be_i,
  input  logic [63:0] h1_wdata_i,
  output logic        h1_rvalid_o,
  output logic [63:0] h1_rdata_o,
  // device
  output logic        dev_req_o,
  input  logic        dev_gnt_i,
  output logic [63:0] dev_addr_o,
  output logic        dev_we_o,
  output logic [7:0]  dev_be_o,
  output logic [63:0] dev_wdata_o,
  input  logic        dev_rvalid_i,
  input  logic [63:0] dev_rdata_i,
  output logic        busy_o
);

  localparam int unsigned PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING_DEPTH);

  typedef enum logic [0:0] {
    ST_OPEN = 1'b0,
    ST_HELD = 1'b1
  } lock_state_e;

  lock_state_e                  state_q;
  logic                         lock_sel_q;
  logic [CNT_W-1:0]             count_q;
  logic [CNT_W-1:0]             count_d;
  logic [PTR_W-1:0]             wptr_q;
  logic [PTR_W-1:0]             rptr_q;
  logic [OUTSTANDING_DEPTH-1:0] id_fifo_q;

  logic policy_sel_s;
  logic sel_s;
  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  // Wrapping pointer increment that also works for non-power-of-two limits.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

`ifdef LUCID64_ARB_ROUND_ROBIN_EN
  logic rr_last_q;

  // Round-robin: on contention the host that was not granted last wins.
  always_comb begin
    policy_sel_s = 1'b0;
    if (h0_req_i && h1_req_i) begin
      policy_sel_s = ~rr_last_q;
    end else if (h1_req_i) begin
      policy_sel_s = 1'b1;
    end else begin
      policy_sel_s = 1'b0;
    end
  end

  // Remember which host was pushed into the ID FIFO most recently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q <= 1'b0;
    end else if (push_s) begin
      rr_last_q <= sel_s;
    end else begin
      rr_last_q <= rr_last_q;
    end
  end
`else
  // Fixed priority: the data stage always beats instruction fetch.
  always_comb begin
    policy_sel_s = 1'b0;
    if (h1_req_i) begin
      policy_sel_s = 1'b1;
    end else begin
      policy_sel_s = 1'b0;
    end
  end
`endif

  // Selection, address-phase forwarding, grant fan-out and response routing.
  always_comb begin
    sel_s   = (state_q == ST_HELD) ? lock_sel_q : policy_sel_s;
    full_s  = (count_q == CNT_FULL);
    empty_s = (count_q == '0);
    head_s  = id_fifo_q[rptr_q];

    // Outputs forced low while reset is asserted, even with hosts requesting.
    dev_req_o   = rst_ni & (h0_req_i | h1_req_i) & ~full_s;
    dev_addr_o  = sel_s ? h1_addr_i  : h0_addr_i;
    dev_we_o    = sel_s ? h1_we_i    : h0_we_i;
    dev_be_o    = sel_s ? h1_be_i    : h0_be_i;
    dev_wdata_o = sel_s ? h1_wdata_i : h0_wdata_i;

    push_s   = dev_req_o & dev_gnt_i;
    h0_gnt_o = push_s & ~sel_s;
    h1_gnt_o = push_s & sel_s;

    // Responses with nothing outstanding are dropped.
    pop_s       = rst_ni & dev_rvalid_i & ~empty_s;
    h0_rvalid_o = pop_s & ~head_s;
    h1_rvalid_o = pop_s & head_s;
    h0_rdata_o  = dev_rdata_i;
    h1_rdata_o  = dev_rdata_i;

    busy_o = ~empty_s;
  end

  // Outstanding count: push and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ID FIFO storage and pointers, holding the issuing host of each transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_fifo_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push_s) begin
        id_fifo_q[wptr_q] <= sel_s;
        wptr_q            <= ptr_inc(wptr_q);
      end else begin
        wptr_q <= wptr_q;
      end
      if (pop_s) begin
        rptr_q <= ptr_inc(rptr_q);
      end else begin
        rptr_q <= rptr_q;
      end
    end
  end

  // Lock FSM: keep a stalled address phase on the same host until granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_OPEN;
      lock_sel_q <= 1'b0;
    end else begin
      case (state_q)
        ST_OPEN: begin
          if (dev_req_o && !dev_gnt_i) begin
            state_q    <= ST_HELD;
            lock_sel_q <= sel_s;
          end else begin
            state_q    <= ST_OPEN;
            lock_sel_q <= lock_sel_q;
          end
        end
        ST_HELD: begin
          if (dev_gnt_i) begin
            state_q <= ST_OPEN;
          end else begin
            state_q <= ST_HELD;
          end
          lock_sel_q <= lock_sel_q;
        end
        default: begin
          state_q    <= ST_OPEN;
          lock_sel_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed scenarios with literal
// expectations, then randomized OBI traffic checked every cycle against a
// queue-based model of the arbiter. Honours LUCID64_ARB_ROUND_ROBIN_EN.
module tb_obi_mem_arbiter;

  localparam int DEPTH = 2;
`ifdef LUCID64_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        h0_req_i, h0_gnt_o, h0_we_i, h0_rvalid_o;
  logic [63:0] h0_addr_i, h0_wdata_i, h0_rdata_o;
  logic [7:0]  h0_be_i;
  logic        h1_req_i, h1_gnt_o, h1_we_i, h1_rvalid_o;
  logic [63:0] h1_addr_i, h1_wdata_i, h1_rdata_o;
  logic [7:0]  h1_be_i;
  logic        dev_req_o, dev_gnt_i, dev_we_o, dev_rvalid_i, busy_o;
  logic [63:0] dev_addr_o, dev_wdata_o, dev_rdata_i;
  logic [7:0]  dev_be_o;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  int q[$];
  int pend    = -1;
  bit rr_last = 1'b0;
  bit keep0   = 1'b0;
  bit keep1   = 1'b0;

  obi_mem_arbiter #(.OUTSTANDING_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .h0_req_i(h0_req_i), .h0_gnt_o(h0_gnt_o), .h0_addr_i(h0_addr_i), .h0_we_i(h0_we_i),
    .h0_be_i(h0_be_i), .h0_wdata_i(h0_wdata_i), .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o),
    .h1_req_i(h1_req_i), .h1_gnt_o(h1_gnt_o), .h1_addr_i(h1_addr_i), .h1_we_i(h1_we_i),
    .h1_be_i(h1_be_i), .h1_wdata_i(h1_wdata_i), .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o), .dev_rvalid_i(dev_rvalid_i),
    .dev_rdata_i(dev_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check all outputs against the model for the current cycle, then advance
  // the model across the coming clock edge.
  task automatic model_cycle();
    bit r0, r1, full, ereq, push, pop;
    int sel;
    logic [63:0] eaddr, ewdata;
    logic [7:0]  ebe;
    logic        ewe;
    r0   = h0_req_i;
    r1   = h1_req_i;
    full = (q.size() == DEPTH);
    if (pend >= 0) sel = pend;
    else if (r0 && r1) sel = RR ? (rr_last ? 0 : 1) : 1;
    else sel = r1 ? 1 : 0;
    ereq = (r0 || r1) && !full;
    push = ereq && dev_gnt_i;
    pop  = dev_rvalid_i && (q.size() > 0);
    chk("dev_req", dev_req_o, ereq);
    chk("h0_gnt", h0_gnt_o, push && sel == 0);
    chk("h1_gnt", h1_gnt_o, push && sel == 1);
    chk("busy", busy_o, q.size() != 0);
    chk("h0_rvalid", h0_rvalid_o, pop && q[0] == 0);
    chk("h1_rvalid", h1_rvalid_o, pop && q[0] == 1);
    if (ereq) begin
      eaddr  = (sel == 1) ? h1_addr_i  : h0_addr_i;
      ewe    = (sel == 1) ? h1_we_i    : h0_we_i;
      ebe    = (sel == 1) ? h1_be_i    : h0_be_i;
      ewdata = (sel == 1) ? h1_wdata_i : h0_wdata_i;
      chk("dev_addr", dev_addr_o, eaddr);
      chk("dev_we", dev_we_o, ewe);
      chk("dev_be", dev_be_o, ebe);
      chk("dev_wdata", dev_wdata_o, ewdata);
    end
    if (pop) begin
      if (q[0] == 0) chk("h0_rdata", h0_rdata_o, dev_rdata_i);
      else chk("h1_rdata", h1_rdata_o, dev_rdata_i);
      void'(q.pop_front());
    end
    if (push) begin
      q.push_back(sel);
      rr_last = sel[0];
    end
    pend  = (ereq && !dev_gnt_i) ? sel : -1;
    keep0 = r0 && !(push && sel == 0);
    keep1 = r1 && !(push && sel == 1);
  endtask

  task automatic set_in(input bit r0, input logic [63:0] a0, input bit r1, input logic [63:0] a1,
                        input bit g, input bit rv, input logic [63:0] rd);
    @(negedge clk);
    h0_req_i = r0; h0_addr_i = a0; h0_we_i = 1'b0; h0_be_i = 8'hFF; h0_wdata_i = 64'h0;
    h1_req_i = r1; h1_addr_i = a1; h1_we_i = 1'b1; h1_be_i = 8'h0F; h1_wdata_i = 64'h1111_2222_3333_4444;
    dev_gnt_i = g; dev_rvalid_i = rv; dev_rdata_i = rd;
    #2;
  endtask

  // Hold reset for two cycles with every input active; outputs must stay low.
  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    h0_req_i = 1'b1; h1_req_i = 1'b1; dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("rst_dev_req", dev_req_o, 1'b0);
      chk("rst_h0_gnt", h0_gnt_o, 1'b0);
      chk("rst_h1_gnt", h1_gnt_o, 1'b0);
      chk("rst_h0_rvalid", h0_rvalid_o, 1'b0);
      chk("rst_h1_rvalid", h1_rvalid_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      @(negedge clk);
    end
    rst_ni = 1'b1;
    h0_req_i = 1'b0; h1_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0;
    q.delete();
    pend = -1; rr_last = 1'b0; keep0 = 1'b0; keep1 = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    h0_req_i = 1'b0; h0_addr_i = '0; h0_we_i = 1'b0; h0_be_i = '0; h0_wdata_i = '0;
    h1_req_i = 1'b0; h1_addr_i = '0; h1_we_i = 1'b0; h1_be_i = '0; h1_wdata_i = '0;
    dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_rdata_i = '0;
    do_reset();

    // Single read from host 0
    set_in(1'b1, 64'h1000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    chk("t1_h0_gnt", h0_gnt_o, 1'b1);
    chk("t1_addr", dev_addr_o, 64'h1000);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'hDEADBEEF);
    chk("t1_h0_rvalid", h0_rvalid_o, 1'b1);
    chk("t1_h0_rdata", h0_rdata_o, 64'hDEADBEEF);
    chk("t1_h1_rvalid", h1_rvalid_o, 1'b0);
    chk("t1_busy", busy_o, 1'b1);
    model_cycle();

    // Both hosts request every cycle, device always grants
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 64'h2000 + 64'(i), 1'b1, 64'h3000 + 64'(i), 1'b1, i != 0, 64'(i));
      chk("t2_h1_gnt", h1_gnt_o, RR ? ((i % 2) == 0) : 1'b1);
      chk("t2_h0_gnt", h0_gnt_o, RR ? ((i % 2) == 1) : 1'b0);
      model_cycle();
    end
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h55);
    model_cycle();

    // Stalled address phase stays on host 0 although host 1 joins
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 64'hA000, i >= 1, 64'hB000, 1'b0, 1'b0, 64'h0);
      chk("t3_addr_held", dev_addr_o, 64'hA000);
      chk("t3_no_gnt", h0_gnt_o | h1_gnt_o, 1'b0);
      model_cycle();
    end
    set_in(1'b1, 64'hA000, 1'b1, 64'hB000, 1'b1, 1'b0, 64'h0);
    chk("t3_h0_gnt", h0_gnt_o, 1'b1);
    chk("t3_h1_gnt0", h1_gnt_o, 1'b0);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b1, 64'hB000, 1'b1, 1'b0, 64'h0);
    chk("t3_h1_gnt", h1_gnt_o, 1'b1);
    chk("t3_addr_b", dev_addr_o, 64'hB000);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h77);
    chk("t3_rsp0", h0_rvalid_o, 1'b1);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h88);
    chk("t3_rsp1", h1_rvalid_o, 1'b1);
    model_cycle();

    // FIFO full stall and in-order routing
    set_in(1'b1, 64'hC000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b1, 64'hD000, 1'b1, 1'b0, 64'h0);
    chk("t4_h1_gnt", h1_gnt_o, 1'b1);
    model_cycle();
    set_in(1'b1, 64'hE000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    chk("t4_full_req", dev_req_o, 1'b0);
    chk("t4_full_gnt", h0_gnt_o, 1'b0);
    model_cycle();
    set_in(1'b1, 64'hE000, 1'b0, 64'h0, 1'b1, 1'b1, 64'h1234);
    chk("t4_pop_no_unblock", dev_req_o, 1'b0);
    chk("t4_rsp_h0", h0_rvalid_o, 1'b1);
    chk("t4_rdata_h0", h0_rdata_o, 64'h1234);
    model_cycle();
    set_in(1'b1, 64'hE000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    chk("t4_third_gnt", h0_gnt_o, 1'b1);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h5678);
    chk("t4_rsp_h1", h1_rvalid_o, 1'b1);
    chk("t4_rsp_h1_not_h0", h0_rvalid_o, 1'b0);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h9ABC);
    chk("t4_rsp_h0b", h0_rvalid_o, 1'b1);
    model_cycle();

    // Spurious response while empty
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'hBAD);
    chk("t5_h0_rvalid", h0_rvalid_o, 1'b0);
    chk("t5_h1_rvalid", h1_rvalid_o, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    model_cycle();

    // Reset with two transactions outstanding
    set_in(1'b1, 64'hF000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    model_cycle();
    set_in(1'b0, 64'h0, 1'b1, 64'hF100, 1'b1, 1'b0, 64'h0);
    model_cycle();
    do_reset();
    set_in(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h42);
    chk("t6_drop_h0", h0_rvalid_o, 1'b0);
    chk("t6_drop_h1", h1_rvalid_o, 1'b0);
    chk("t6_busy", busy_o, 1'b0);
    model_cycle();
    set_in(1'b1, 64'hF200, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    chk("t6_regrant", h0_gnt_o, 1'b1);
    model_cycle();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ((c % 700) == 350) do_reset();
      @(negedge clk);
      if (!keep0) begin
        h0_req_i = 1'($urandom % 2); h0_addr_i = {$urandom, $urandom}; h0_we_i = 1'($urandom);
        h0_be_i = 8'($urandom); h0_wdata_i = {$urandom, $urandom};
      end
      if (!keep1) begin
        h1_req_i = 1'($urandom % 2); h1_addr_i = {$urandom, $urandom}; h1_we_i = 1'($urandom);
        h1_be_i = 8'($urandom); h1_wdata_i = {$urandom, $urandom};
      end
      dev_gnt_i    = ($urandom % 4) != 0;
      dev_rvalid_i = ($urandom % 3) == 0;
      dev_rdata_i  = {$urandom, $urandom};
      #2;
      model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
